// File: rtl/usfft_stream_decoder.sv
// usfft_stream_decoder: unary stochastic FFT output stage. Counts ones per
// lane over a 2^BITWIDTH-cycle window and maps the count to a signed value.
// Ports:
//   iClk, iRst       clock; synchronous active-high reset
//   iClr             abort the current window, return to IDLE
//   iStart           request a new conversion window
//   iReady           consumer accepts the held result
//   iReal, iImg      per-lane bitstreams, bit k is lane k
//   oBusy            high while sampling (RUN)
//   oValid           result held until accepted (HOLD)
//   oReal, oImg      signed lane results, lane k at [k*(BITWIDTH+1) +: BITWIDTH+1]
module usfft_stream_decoder #(
  parameter int BITWIDTH = 8,
  parameter int NUMINPUT = 4
) (
  input  logic                               iClk,
  input  logic                               iRst,
  input  logic                               iClr,
  input  logic                               iStart,
  input  logic                               iReady,
  input  logic [NUMINPUT-1:0]                iReal,
  input  logic [NUMINPUT-1:0]                iImg,
  output logic                               oBusy,
  output logic                               oValid,
  output logic [NUMINPUT*(BITWIDTH+1)-1:0]   oReal,
  output logic [NUMINPUT*(BITWIDTH+1)-1:0]   oImg
);

  localparam int AW = BITWIDTH + 1;

  // Bipolar offset 2^(BITWIDTH-1) expressed in AW bits.
  localparam logic [AW-1:0] HALF =
    {2'b01, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BITWIDTH-1:0] cnt;
  logic                last;
  logic                go;

  logic [AW-1:0] acc_re [NUMINPUT];
  logic [AW-1:0] acc_im [NUMINPUT];
  logic [AW-1:0] sum_re [NUMINPUT];
  logic [AW-1:0] sum_im [NUMINPUT];
  logic [AW-1:0] res_re [NUMINPUT];
  logic [AW-1:0] res_im [NUMINPUT];

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic; iClr outranks every other request.
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (iClr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (iStart) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (last) begin
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (iReady) begin
            state_nxt = iStart ? RUN : IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------
  always_comb begin
    oBusy  = 1'b0;
    oValid = 1'b0;
    unique case (state)
      RUN:     oBusy  = 1'b1;
      HOLD:    oValid = 1'b1;
      default: begin
        oBusy  = 1'b0;
        oValid = 1'b0;
      end
    endcase
  end

  // Final sample of the window is on the edge where cnt is all ones.
  assign last = (state == RUN) && (cnt == '1);

  // A new window opens from IDLE or straight out of HOLD.
  assign go = (state != RUN) && (state_nxt == RUN);

  // ---------------------------------------------------------------
  // Per-lane sums including this edge's bit, and bipolar results.
  // The sum reaches 2^BITWIDTH at most, which fits AW bits, and the
  // subtraction then spans -2^(BITWIDTH-1) .. +2^(BITWIDTH-1).
  // ---------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUMINPUT; k++) begin
      sum_re[k] = acc_re[k] + AW'(iReal[k]);
      sum_im[k] = acc_im[k] + AW'(iImg[k]);
      res_re[k] = sum_re[k] - HALF;
      res_im[k] = sum_im[k] - HALF;
    end
  end

  // ---------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt <= '0;
    end else if (iClr || go) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Accumulators: live only in RUN, emptied on the last sample so a
  // back-to-back window starts from zero.
  // ---------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int k = 0; k < NUMINPUT; k++) begin
        acc_re[k] <= '0;
        acc_im[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUMINPUT; k++) begin
        if (iClr || (state != RUN) || last) begin
          acc_re[k] <= '0;
          acc_im[k] <= '0;
        end else begin
          acc_re[k] <= sum_re[k];
          acc_im[k] <= sum_im[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Result registers: updated only on a completed window; an abort
  // leaves the previous result visible.
  // ---------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oReal <= '0;
      oImg  <= '0;
    end else if (last && !iClr) begin
      for (int k = 0; k < NUMINPUT; k++) begin
        oReal[k*AW +: AW] <= res_re[k];
        oImg[k*AW +: AW]  <= res_im[k];
      end
    end
  end

endmodule

// File: tb/tb_usfft_stream_decoder.sv
// tb_usfft_stream_decoder: directed bench for usfft_stream_decoder.
// Drives inputs 1ns after each rising edge and samples there too.
module tb_usfft_stream_decoder;

  localparam int BW = 8;
  localparam int NI = 4;
  localparam int AW = BW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          start;
  logic          ready;
  logic [NI-1:0] re_in;
  logic [NI-1:0] im_in;
  logic          busy;
  logic          valid;
  logic [NI*AW-1:0] re_out;
  logic [NI*AW-1:0] im_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NI*AW-1:0] held_re;
  logic [NI*AW-1:0] held_im;

  always #5 clk = ~clk;

  usfft_stream_decoder #(
    .BITWIDTH(BW),
    .NUMINPUT(NI)
  ) dut (
    .iClk  (clk),
    .iRst  (rst),
    .iClr  (clr),
    .iStart(start),
    .iReady(ready),
    .iReal (re_in),
    .iImg  (im_in),
    .oBusy (busy),
    .oValid(valid),
    .oReal (re_out),
    .oImg  (im_out)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lane0 always, lane1 every other, lane2 one in four, lane3 never
  function automatic logic [NI-1:0] lane_pat(input int i);
    return {1'b0, (i % 4 == 0), (i % 2 == 0), 1'b1};
  endfunction

  task automatic check_lanes(
    input string tag, input logic [NI*AW-1:0] bus,
    input int e3, input int e2, input int e1, input int e0);
    int e [NI];
    int got;
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < NI; k++) begin
      got = int'($signed(bus[k*AW +: AW]));
      chk($sformatf("%s[%0d]", tag, k), got, e[k]);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive samples [from, from+n); pat selects the lane pattern.
  task automatic run_samples(
    input int from, input int n,
    input logic [NI-1:0] r, input logic [NI-1:0] m,
    input bit pat);
    for (int i = from; i < from + n; i++) begin
      re_in = pat ? lane_pat(i) : r;
      im_in = pat ? lane_pat(i) : m;
      tick();
    end
    re_in = '0;
    im_in = '0;
  endtask

  // Full window with the valid edge checked at exactly 256 samples.
  task automatic full_window(
    input string tag,
    input logic [NI-1:0] r, input logic [NI-1:0] m,
    input bit pat);
    run_samples(0, (1 << BW) - 1, r, m, pat);
    chk({tag, "_valid_early"}, int'(valid), 0);
    chk({tag, "_busy_late"}, int'(busy), 1);
    run_samples((1 << BW) - 1, 1, r, m, pat);
    chk({tag, "_valid"}, int'(valid), 1);
    chk({tag, "_busy_done"}, int'(busy), 0);
  endtask

  task automatic accept();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    clr   = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    re_in = '0;
    im_in = '0;
    tick();
    tick();
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_re", int'(re_out), 0);
    chk("rst_im", int'(im_out), 0);
    rst = 1'b0;
    tick();

    // all ones on real, all zeros on imag
    do_start();
    chk("w1_busy", int'(busy), 1);
    full_window("w1", 4'hF, 4'h0, 1'b0);
    check_lanes("w1_re", re_out, 128, 128, 128, 128);
    check_lanes("w1_im", im_out, -128, -128, -128, -128);

    // backpressure: result holds for 20 cycles
    held_re = re_out;
    held_im = im_out;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid", int'(valid), 1);
      chk("bp_re", int'(re_out == held_re), 1);
      chk("bp_im", int'(im_out == held_im), 1);
    end
    accept();
    chk("acc_valid", int'(valid), 0);
    chk("acc_busy", int'(busy), 0);
    tick();
    chk("idle_busy", int'(busy), 0);

    // lane independence
    do_start();
    full_window("w2", '0, '0, 1'b1);
    check_lanes("w2_re", re_out, -128, -64, 0, 128);
    check_lanes("w2_im", im_out, -128, -64, 0, 128);

    // back-to-back: accept and restart on the same edge
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_valid", int'(valid), 0);
    full_window("w3", 4'hF, 4'hF, 1'b0);
    check_lanes("w3_re", re_out, 128, 128, 128, 128);
    check_lanes("w3_im", im_out, 128, 128, 128, 128);
    accept();

    // abort at sample 100
    do_start();
    run_samples(0, 100, 4'hA, 4'h5, 1'b0);
    clr   = 1'b1;
    re_in = 4'hF;
    im_in = 4'hF;
    tick();
    clr   = 1'b0;
    re_in = '0;
    im_in = '0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_valid", int'(valid), 0);
    check_lanes("clr_re", re_out, 128, 128, 128, 128);
    check_lanes("clr_im", im_out, 128, 128, 128, 128);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("clr_idle_valid", int'(valid), 0);
    end

    // iClr with iStart in IDLE wins
    clr   = 1'b1;
    start = 1'b1;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    chk("clr_start_busy", int'(busy), 0);
    tick();
    chk("clr_start_busy2", int'(busy), 0);

    // clean window after abort
    do_start();
    full_window("w4", 4'b0101, 4'b1010, 1'b0);
    check_lanes("w4_re", re_out, -128, 128, -128, 128);
    check_lanes("w4_im", im_out, 128, -128, 128, -128);
    accept();

    // reset mid-run, with iStart held during reset
    do_start();
    run_samples(0, 50, 4'hF, 4'hF, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    chk("rrun_busy", int'(busy), 0);
    chk("rrun_valid", int'(valid), 0);
    chk("rrun_re", int'(re_out), 0);
    chk("rrun_im", int'(im_out), 0);
    tick();
    chk("rrun_start_busy", int'(busy), 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rrun_idle_busy", int'(busy), 0);

    // window after reset, then reset in HOLD
    do_start();
    full_window("w5", '0, '0, 1'b1);
    check_lanes("w5_re", re_out, -128, -64, 0, 128);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rhold_valid", int'(valid), 0);
    chk("rhold_busy", int'(busy), 0);
    chk("rhold_re", int'(re_out), 0);
    chk("rhold_im", int'(im_out), 0);
    tick();
    chk("rhold_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
